// File: rtl/rr_arb_4_2.sv
// Four-requester round-robin arbiter driving a 2-bit selector and a registered shared data output.
// Optional HOLD_LIMIT_EN: forces rotation after MAX_HOLD consecutive granted cycles when others wait.
module rr_arb_4_2 #(
  parameter int DW       = 2,
  parameter int MAX_HOLD = 4,
  parameter int HCW      = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    REQ,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  input  logic [DW-1:0] D,
  output logic [3:0]    GNT,
  output logic [1:0]    SEL,
  output logic [DW-1:0] OUT,
  output logic          VALID
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic [1:0]    r_ptr;
  logic [DW-1:0] r_out;
  logic          r_valid;

  logic          w_any;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;
  logic          w_cur_req;
  logic          w_force;
  logic          w_data_ok;
  logic [DW-1:0] w_data;

  // Search PTR+1, PTR+2, PTR+3, PTR; first requesting index wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_ptr + i[1:0];
      if (!w_any && REQ[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_data = '0;
    case (r_sel)
      2'd0: w_data = A;
      2'd1: w_data = B;
      2'd2: w_data = C;
      2'd3: w_data = D;
      default: w_data = '0;
    endcase
  end

  assign w_cur_req = REQ[r_sel];
  assign w_data_ok = |(r_gnt & REQ);

`ifdef HOLD_LIMIT_EN
  logic [HCW-1:0] r_hold;
  logic           w_other_req;

  assign w_other_req = |(REQ & ~(4'b0001 << r_sel));
  assign w_force     = (r_state == S_GRANT) && w_cur_req && w_other_req &&
                       (r_hold == HCW'(MAX_HOLD - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold <= '0;
    end else if (r_state == S_GRANT && w_cur_req && !w_force) begin
      if (r_hold != HCW'(MAX_HOLD - 1))
        r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_force      = 1'b0;
  assign w_unused_cfg = (MAX_HOLD > 0) ^ (HCW > 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= 2'b11;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_data_ok;
      if (w_data_ok)
        r_out <= w_data;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_ptr   <= w_win;
            r_state <= S_GRANT;
          end else begin
            r_gnt <= '0;
          end
        end
        S_GRANT: begin
          // Release and forced rotation share the same re-arbitration path.
          if (w_cur_req && !w_force) begin
            r_gnt <= r_gnt;
          end else if (w_any) begin
            r_gnt <= 4'b0001 << w_win;
            r_sel <= w_win;
            r_ptr <= w_win;
          end else begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT   = r_gnt;
  assign SEL   = r_sel;
  assign OUT   = r_out;
  assign VALID = r_valid;

endmodule

// File: tb/tb_rr_arb_4_2.sv
// Directed bench for rr_arb_4_2: reference arbiter model feeds a scoreboard queue,
// plus explicit checks of the key behaviours.
module tb_rr_arb_4_2;

  localparam int DW       = 2;
  localparam int MAX_HOLD = 4;
  localparam int HCW      = 8;

  logic          CLK;
  logic          RST;
  logic [3:0]    REQ;
  logic [DW-1:0] A, B, C, D;
  logic [3:0]    GNT;
  logic [1:0]    SEL;
  logic [DW-1:0] OUT;
  logic          VALID;

  rr_arb_4_2 #(.DW(DW), .MAX_HOLD(MAX_HOLD), .HCW(HCW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT), .SEL(SEL), .OUT(OUT), .VALID(VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] out;
    string         tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit            m_busy;
  int            m_ptr;
  logic [3:0]    m_gnt;
  logic [1:0]    m_sel;
  logic          m_valid;
  logic [DW-1:0] m_out;
  int            m_hold;

  function automatic void model_reset();
    m_busy = 0; m_ptr = 3; m_gnt = 4'b0000; m_sel = 2'b00;
    m_valid = 1'b0; m_out = '0; m_hold = 0;
  endfunction

  function automatic void model_edge();
    logic [DW-1:0] d [4];
    int  w;
    bit  any;
    bit  force_rot;
    d[0] = A; d[1] = B; d[2] = C; d[3] = D;
    m_valid = |(m_gnt & REQ);
    if (m_valid) m_out = d[m_sel];
    any = 0; w = 0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (!any && REQ[c]) begin any = 1; w = c; end
    end
    force_rot = 0;
`ifdef HOLD_LIMIT_EN
    force_rot = m_busy && REQ[m_sel] && (m_hold == MAX_HOLD - 1) &&
                ((REQ & ~(4'b0001 << m_sel)) != 4'b0000);
`endif
    if (m_busy && REQ[m_sel] && !force_rot) begin
      if (m_hold < MAX_HOLD - 1) m_hold++;
    end else if (any) begin
      m_busy = 1; m_gnt = 4'b0001 << w; m_sel = 2'(w); m_ptr = w; m_hold = 0;
    end else begin
      m_busy = 0; m_gnt = 4'b0000; m_hold = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_edge();
    e.gnt = m_gnt; e.sel = m_sel; e.valid = m_valid; e.out = m_out; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".gnt"},   GNT,          e.gnt);
    chk({e.tag, ".sel"},   {2'b00, SEL}, {2'b00, e.sel});
    chk({e.tag, ".valid"}, {3'b000, VALID}, {3'b000, e.valid});
    chk({e.tag, ".out"},   {2'b00, OUT}, {2'b00, e.out});
  endtask

  task automatic rand_data();
    A = DW'($urandom); B = DW'($urandom); C = DW'($urandom); D = DW'($urandom);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; REQ = 4'b1111;
    rand_data();
    #1 RST = 1'b1;
    model_reset();

    // 1: reset holds outputs clear despite requests
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst.gnt", GNT, 4'b0000);
      chk("rst.sel", {2'b00, SEL}, 4'b0000);
      chk("rst.out", {2'b00, OUT}, 4'b0000);
      chk("rst.valid", {3'b000, VALID}, 4'b0000);
      rand_data();
    end
    RST = 1'b0;
    tick("t1.first");
    chk("t1.gnt0", GNT, 4'b0001);

    // 2: single request from IDLE
    REQ = 4'b0000;
    tick("t2.idle0");
    tick("t2.idle1");
    REQ = 4'b0100; C = 2'b10;
    tick("t2.grant");
    chk("t2.gntC", GNT, 4'b0100);
    chk("t2.selC", {2'b00, SEL}, 4'b0010);
    tick("t2.data");
    chk("t2.outC", {2'b00, OUT}, 4'b0010);
    chk("t2.validC", {3'b000, VALID}, 4'b0001);
    REQ = 4'b0000;
    tick("t2.drop");
    chk("t2.gnt_off", GNT, 4'b0000);
    chk("t2.sel_hold", {2'b00, SEL}, 4'b0010);
    tick("t2.after");
    chk("t2.valid_off", {3'b000, VALID}, 4'b0000);
    chk("t2.out_hold", {2'b00, OUT}, 4'b0010);

    // 3: rotation with every granted requester releasing for one cycle
    REQ = 4'b0001; rand_data();
    tick("t3.start");
    chk("t3.sel0", {2'b00, SEL}, 4'b0000);
    for (int j = 0; j < 4; j++) begin
      logic [3:0] oh;
      oh  = 4'b0001 << ((j + 1) % 4);
      REQ = ~(4'b0001 << j);
      rand_data();
      tick("t3.rot");
      chk("t3.gnt_onehot", GNT, oh);
      chk("t3.sel_seq", {2'b00, SEL}, 4'((j + 1) % 4));
    end

    // 4: release hands over at the same edge, data follows next edge
    REQ = 4'b0011; rand_data();
    tick("t4.hold");
    chk("t4.gntA", GNT, 4'b0001);
    REQ = 4'b0010; B = 2'b01;
    tick("t4.handover");
    chk("t4.gntB", GNT, 4'b0010);
    chk("t4.selB", {2'b00, SEL}, 4'b0001);
    tick("t4.data");
    chk("t4.outB", {2'b00, OUT}, 4'b0001);
    chk("t4.validB", {3'b000, VALID}, 4'b0001);

    // 5: constant contention (forced rotation only with the hold limit)
    REQ = 4'b0000;
    tick("t5.idle");
    REQ = 4'b0011;
    for (int t = 0; t < 12; t++) begin
      logic [3:0] eg;
`ifdef HOLD_LIMIT_EN
      eg = ((t / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      eg = 4'b0001;
`endif
      rand_data();
      tick("t5.contend");
      chk("t5.gnt_pattern", GNT, eg);
    end
    REQ = 4'b0001;
    for (int t = 0; t < 8; t++) begin
      tick("t5.solo");
      chk("t5.gnt_solo", GNT, 4'b0001);
    end

    // 6: asynchronous reset mid-grant, restart from requester 0
    REQ = 4'b1000; D = 2'b11;
    tick("t6.grantD");
    chk("t6.gntD", GNT, 4'b1000);
    tick("t6.validD");
    chk("t6.validD1", {3'b000, VALID}, 4'b0001);
    #3 RST = 1'b1;
    #1;
    model_reset();
    chk("t6.async_gnt", GNT, 4'b0000);
    chk("t6.async_sel", {2'b00, SEL}, 4'b0000);
    chk("t6.async_out", {2'b00, OUT}, 4'b0000);
    chk("t6.async_valid", {3'b000, VALID}, 4'b0000);
    @(posedge CLK); #1;
    RST = 1'b0; REQ = 4'b1001; rand_data();
    tick("t6.restart");
    chk("t6.gnt_restart", GNT, 4'b0001);
    tick("t6.restart_data");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_empty got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_4_2.md
Name: rr_arb_4_2

Overview:
Round-robin arbiter and sequencer for the shared 4-to-1 2-bit selector path. Four requesters each present DW-bit data and a request line. The block grants one requester at a time and drives the selector code SEL. It also registers the selected data onto a shared output with a valid strobe. It sits between the requesters and the downstream consumer of the shared bus.

Parameters:
DW, 2, data width of each requester input and of OUT
MAX_HOLD, 4, max consecutive granted cycles before forced rotation (used only with HOLD_LIMIT_EN); legal range 1..255
HCW, 8, hold counter width; must satisfy 2^HCW > MAX_HOLD

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
REQ  input  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D
A  input  DW  requester 0 data
B  input  DW  requester 1 data
C  input  DW  requester 2 data
D  input  DW  requester 3 data
GNT  output  4  one-hot grant, registered
SEL  output  2  selector code of current/last grant, registered (00=A, 01=B, 10=C, 11=D)
OUT  output  DW  registered selected data
VALID  output  1  OUT holds data from a granted, requesting source

Behaviour:
- Reset (async, immediate on RST=1):
  - GNT=0000, SEL=00, OUT=0, VALID=0, state=IDLE.
  - Last-grant pointer PTR=11, so the first search starts at requester 0.
  - Hold counter=0.
- States: IDLE, GRANT.
- Search order: PTR+1, PTR+2, PTR+3, PTR (all mod 4); the first set REQ bit wins.
- IDLE:
  - REQ=0000: remain; GNT=0000; SEL holds its last value (no toggling).
  - Any REQ set: at the edge, GNT=onehot(w), SEL=w, PTR=w, state=GRANT.
- GRANT, REQ[SEL]=1 (no forced rotation): hold GNT/SEL; hold counter increments.
- GRANT, REQ[SEL]=0, other REQ pending:
  - Re-arbitrate at the same edge (no bubble cycle).
  - Search starts from PTR+1; the releasing requester is excluded because its REQ is 0.
  - New GNT/SEL/PTR load; hold counter=0.
- GRANT, REQ[SEL]=0, none pending: GNT=0000, state=IDLE, SEL holds, hold counter=0.
- Data path (registered, one cycle behind grant):
  - Every edge: VALID <= |(GNT & REQ).
  - When that term is 1, OUT <= data selected by SEL (A/B/C/D); otherwise OUT holds its value.
  - Latency: REQ sampled at edge k gives GNT at edge k; first valid OUT is at edge k+1.
- REQ deasserted by a requester that is not granted: no effect.
- GNT is always one-hot or zero, never multi-hot.
- RST asserted mid-grant: all outputs go to reset values immediately; arbitration after release restarts from requester 0.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - Forced rotation occurs when the hold counter reaches MAX_HOLD-1 while REQ[SEL]=1 and another REQ bit is set.
  - At that edge the block re-arbitrates from PTR+1 and the counter clears.
  - If no other request is pending, the counter saturates and the grant continues.
- Not defined: no hold counter is synthesised and a grant lasts as long as REQ[SEL]=1.
- MAX_HOLD and HCW are ignored when the macro is not defined.

Test Plan:
1. Hold RST=1 with REQ=1111 and random data -> GNT=0000, SEL=00, OUT=00, VALID=0 throughout. Release RST -> GNT=0001 at the first edge.
2. REQ=0100, C=10 from IDLE -> edge k: GNT=0100, SEL=10. Edge k+1: OUT=10, VALID=1. Drop REQ -> next edge GNT=0000, SEL stays 10. Following edge: VALID=0, OUT stays 10.
3. REQ=1111, each granted requester drops REQ for exactly one cycle after a single granted cycle -> SEL sequence 00,01,10,11,00 with no IDLE cycles and GNT always one-hot.
4. REQ=0011, GNT=0001, then drop REQ[0] -> same edge GNT=0010, SEL=01. Next edge: OUT=B, VALID=1 (no bubble).
5. HOLD_LIMIT_EN defined, MAX_HOLD=4, REQ=0011 held constant -> GNT=0001 for 4 cycles, then 0010 for 4 cycles, then 0001. With REQ=0001 only -> GNT=0001 indefinitely. Without the macro, REQ=0011 held constant -> GNT=0001 indefinitely.
6. Assert RST asynchronously mid-cycle while GNT=1000, VALID=1 -> outputs clear before the next edge. After release with REQ=1001 -> grant goes to requester 0 (GNT=0001).
